logicnet_stream_ctrl: RTL

- Streaming controller that feeds feature vectors into the free-running, non-stallable LogicNet inference pipeline (PIPE_LAT register stages, no enable) and returns classifications over a valid/ready interface.
- Tags in-flight samples with a valid shift register and captures results into an output FIFO.
- Throttles input with a credit scheme so no result is ever lost under downstream backpressure.
- Sits between the packet/feature front end and the logicnet core.

---
 rtl/logicnet_stream_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/logicnet_stream_ctrl.sv
// Stream controller for the non-stallable LogicNet core: tags in-flight samples,
// buffers results in a FWFT FIFO and throttles input by credit so no result is lost.
module logicnet_stream_ctrl #(
  parameter int IN_W       = 512,
  parameter int OUT_W      = 2,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + PIPE_LAT + 1);

  logic [PIPE_LAT-1:0] vld;
  logic [OUT_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       count;
  logic [SW-1:0]       inflight;
  logic                acc;
  logic                wr;
  logic                pop;

  // Credit covers both buffered and in-flight results, so the FIFO can always absorb
  // every result the core is already committed to producing.
  always_comb begin
    inflight = SW'(count);
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + SW'(vld[i]);
    end
  end

  assign s_ready = rst && (inflight < SW'(FIFO_DEPTH));
  assign acc     = s_valid && s_ready;
  assign core_in = acc ? s_data : '0;
  assign wr      = vld[PIPE_LAT-1];
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? mem[rptr] : '0;
  assign busy    = m_valid || (vld != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      result_cnt <= '0;
    end else begin
      vld[0] <= acc;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr       <= rptr + 1'b1;
        result_cnt <= result_cnt + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= core_out;
  end

endmodule
